// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: iterative AES MixColumns, one column per cycle through a shared datapath, with final-round bypass.
module mixcolumns_iter (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] state,
  input  logic             bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] newstate
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  fsm_t         r_fsm, w_nxt;
  logic [127:0] r_in, r_res;
  logic         r_byp;
  logic [1:0]   r_col;
  logic [31:0]  w_col, w_mix;
  logic [7:0]   w_a0, w_a1, w_a2, w_a3, w_x0, w_x1, w_x2, w_x3;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // ~r_col selects column 0 from the top 32 bits down to column 3 at the bottom
  assign w_col = r_in[{~r_col, 5'b0} +: 32];
  assign {w_a0, w_a1, w_a2, w_a3} = w_col;
  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);
  assign w_mix = r_byp ? w_col : {w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3,
                                  w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3,
                                  w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3,
                                  w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3};
  always_comb begin
    w_nxt = r_fsm;
    w_nxt = (r_fsm == IDLE && in_valid)     ? BUSY :
            (r_fsm == BUSY && r_col == 2'd3) ? DONE :
            (r_fsm == DONE && out_ready)    ? IDLE : r_fsm;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= IDLE;
      r_in  <= '0;
      r_res <= '0;
      r_byp <= 1'b0;
      r_col <= '0;
    end else begin
      r_fsm <= w_nxt;
      if (r_fsm == IDLE && in_valid) begin
        r_in  <= state;
        r_byp <= bypass;
        r_col <= '0;
      end
      if (r_fsm == BUSY) begin
        r_res[{~r_col, 5'b0} +: 32] <= w_mix;
        r_col <= r_col + 2'd1;
      end
    end
  end
  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign newstate  = r_res;
endmodule
